// File: rtl/receptor_serial.sv
// UART-style 8N1 serial receiver (LSB first, idle high) with one-cycle pronto/erro_frame strobes.
// Define RX_PARIDADE_EN to expect an even-parity bit between the data bits and the stop bit.
module receptor_serial #(
  parameter int CICLOS_POR_BIT = 434,
  parameter int DATA_BITS      = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [7:0] dado,
  output logic       pronto,
  output logic       erro_frame,
  output logic [2:0] db_estado
);

  localparam int TW = $clog2(CICLOS_POR_BIT);
  localparam logic [TW-1:0] LIM_BIT  = TW'(CICLOS_POR_BIT - 1);
  localparam logic [TW-1:0] LIM_MEIO = TW'(CICLOS_POR_BIT / 2 - 1);
  localparam logic [2:0]    ULT_BIT  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    INICIO   = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    PARADA   = 3'd4,
    ESPERA   = 3'd5
  } estado_t;

  estado_t               estado, estado_n;
  logic [1:0]            sync_q;
  logic                  rx_s;
  logic [TW-1:0]         timer;
  logic                  tick;
  logic [2:0]            bit_idx;
  logic [DATA_BITS-1:0]  sr;
  logic [7:0]            sr_ext;
`ifdef RX_PARIDADE_EN
  logic                  par_q;
`endif

  // Line is asynchronous; everything downstream looks only at rx_s.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], entrada_serial};
  end
  assign rx_s = sync_q[1];

  // The start bit is checked half a bit in, which puts every later sample mid-bit.
  assign tick = (timer == ((estado == INICIO) ? LIM_MEIO : LIM_BIT));

  always_comb begin
    sr_ext = '0;
    sr_ext[DATA_BITS-1:0] = sr;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= estado_n;
  end

  always_comb begin
    estado_n = estado;
    case (estado)
      OCIOSO: if (!rx_s) estado_n = INICIO;
      INICIO: if (tick) estado_n = rx_s ? OCIOSO : DADOS;
      DADOS:
        if (tick && bit_idx == ULT_BIT) begin
`ifdef RX_PARIDADE_EN
          estado_n = PARIDADE;
`else
          estado_n = PARADA;
`endif
        end
`ifdef RX_PARIDADE_EN
      PARIDADE: if (tick) estado_n = PARADA;
`endif
      PARADA: if (tick) estado_n = rx_s ? OCIOSO : ESPERA;
      ESPERA: if (rx_s) estado_n = OCIOSO;
      default: estado_n = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer      <= '0;
      bit_idx    <= '0;
      sr         <= '0;
      dado       <= '0;
      pronto     <= 1'b0;
      erro_frame <= 1'b0;
`ifdef RX_PARIDADE_EN
      par_q      <= 1'b0;
`endif
    end else begin
      pronto     <= 1'b0;
      erro_frame <= 1'b0;
      if (estado == OCIOSO || estado == ESPERA || tick) timer <= '0;
      else                                              timer <= timer + 1'b1;
      if (estado == INICIO) bit_idx <= '0;
      if (estado == DADOS && tick) begin
        sr      <= {rx_s, sr[DATA_BITS-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end
`ifdef RX_PARIDADE_EN
      if (estado == PARIDADE && tick) par_q <= rx_s;
`endif
      if (estado == PARADA && tick) begin
        if (!rx_s) begin
          erro_frame <= 1'b1;
`ifdef RX_PARIDADE_EN
        end else if ((^sr) != par_q) begin
          erro_frame <= 1'b1;
`endif
        end else begin
          dado   <= sr_ext;
          pronto <= 1'b1;
        end
      end
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_receptor_serial.sv
// Randomized scoreboard bench for receptor_serial: frames are modelled as byte-level events
// pushed into a queue; a monitor pops one per pronto/erro_frame strobe.
module tb_receptor_serial;
  localparam int CPB = 16;
`ifdef RX_PARIDADE_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       entrada_serial = 1'b1;
  logic [7:0] dado;
  logic       pronto, erro_frame;
  logic [2:0] db_estado;

  receptor_serial #(.CICLOS_POR_BIT(CPB), .DATA_BITS(8)) dut (
    .clock(clock), .reset(reset), .entrada_serial(entrada_serial),
    .dado(dado), .pronto(pronto), .erro_frame(erro_frame), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Pin fall to strobe: (frame bits - 0.5) bit times plus synchroniser/register slack.
  exp_t m_e;
  int   lat, lat_ref;
  always @(negedge clock) begin
    if (reset && (pronto || erro_frame)) begin
      chk("exclusive", {31'b0, pronto & erro_frame}, 32'd0);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe actual pronto=%0b erro=%0b required none", pronto, erro_frame);
      end else begin
        m_e     = q.pop_front();
        lat     = cyc - m_e.start;
        lat_ref = ((2 * NBITS - 1) * CPB) / 2 + 3;
        chk("kind_err", {31'b0, erro_frame}, {31'b0, m_e.err});
        chk("dado", {24'b0, dado}, {24'b0, m_e.data});
        chk("latency_in_window", {31'b0, (lat >= lat_ref - 4) && (lat <= lat_ref + 4)}, 32'd1);
      end
    end
  end

  task automatic bit_out(input logic b);
    entrada_serial = b;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    entrada_serial = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    exp_t e;
    logic p;
    e.start = cyc;
    if (!stop_ok || !par_ok) begin
      e.err  = 1'b1;
      e.data = last_good;
    end else begin
      e.err     = 1'b0;
      e.data    = d;
      last_good = d;
    end
    q.push_back(e);
    p = (^d) ^ !par_ok;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef RX_PARIDADE_EN
    bit_out(p);
`endif
    bit_out(stop_ok);
    if (!stop_ok) begin
      repeat (2 * CPB) @(posedge clock);
      #1;
      chk("espera_state", {29'b0, db_estado}, 32'd5);
      idle(CPB);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    bit so, po;
    int gap;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_dado", {24'b0, dado}, 32'd0);
    chk("rst_pronto", {31'b0, pronto}, 32'd0);
    chk("rst_erro", {31'b0, erro_frame}, 32'd0);
    chk("rst_estado", {29'b0, db_estado}, 32'd0);
    reset = 1'b1;
    idle(3);

    send_frame(8'hA5, 1'b1, 1'b1);
    idle(CPB);
    chk("idle_after_a5", {29'b0, db_estado}, 32'd0);

    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    idle(CPB);

    // Start glitch: four clocks low must not produce a frame.
    entrada_serial = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    entrada_serial = 1'b1;
    repeat (9) @(posedge clock);
    #1;
    chk("glitch_back_idle", {29'b0, db_estado}, 32'd0);
    idle(CPB);

    send_frame(8'h3C, 1'b0, 1'b1);
    chk("idle_after_break", {29'b0, db_estado}, 32'd0);
    send_frame(8'h11, 1'b1, 1'b1);
    idle(CPB);

    // Reset in the middle of 0x55: partial byte is dropped.
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(i[0] ? 1'b0 : 1'b1);
    reset = 1'b0;
    entrada_serial = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("midrst_dado", {24'b0, dado}, 32'd0);
    chk("midrst_estado", {29'b0, db_estado}, 32'd0);
    last_good = 8'h00;
    reset = 1'b1;
    idle(CPB);
    send_frame(8'h81, 1'b1, 1'b1);
    idle(CPB);

`ifdef RX_PARIDADE_EN
    send_frame(8'h07, 1'b1, 1'b1);
    idle(CPB);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(CPB);
`endif

    for (int n = 0; n < 40; n++) begin
      d  = 8'($urandom);
      so = ($urandom_range(0, 4) != 0);
`ifdef RX_PARIDADE_EN
      po = ($urandom_range(0, 4) != 0);
`else
      po = 1'b1;
`endif
      gap = $urandom_range(0, 20);
      send_frame(d, so, po);
      if (gap > 0) idle(gap);
    end

    idle(4 * CPB);
    chk("queue_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
